seq_alu: RTL

Parametrised, handshaked successor to the combinational datapath ALU. It registers every result and a persistent NZCV flag register, and adds an iterative shift-add multiplier and compare. Sits between the register-read stage and writeback of the multicycle core. It accepts one operation per valid/ready transfer and holds its result until the consumer takes it.

---
 rtl/seq_alu.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result, persistent NZCV flags
// and an iterative LSB-first shift-add multiplier.
module seq_alu #(
   parameter int WIDTH     = 32,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [WIDTH-1:0]     op1Reg,
   input  logic [WIDTH-1:0]     op2Reg,
   input  logic                 immediateMode,
   input  logic [IMM_WIDTH-1:0] immediate,
   input  logic                 aluMode,
   input  logic [2:0]           aluFunc,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [WIDTH-1:0]     results,
   output logic [3:0]           flags,
   output logic                 busy
);

   localparam int SHW   = $clog2(WIDTH);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [WIDTH-1:0]     op2_s;
   logic                 is_mul_s;
   logic                 accept_s;
   logic                 mul_last_s;
   logic [WIDTH:0]       add_s;
   logic [WIDTH:0]       sub_s;
   logic [WIDTH:0]       lsl_s;
   logic [WIDTH:0]       lsr_s;
   logic                 big_shift_s;
   logic [WIDTH-1:0]     alu_res_s;
   logic                 alu_c_s;
   logic                 alu_v_s;
   logic [3:0]           alu_flags_s;
   logic [3:0]           mul_flags_s;
   logic [2*WIDTH-1:0]   acc_r;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [WIDTH-1:0]     results_r;
   logic [3:0]           flags_r;
   logic                 out_valid_r;
   logic                 busy_r;

   function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] res,
                                       input logic             c,
                                       input logic             v);
      return {res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
   endfunction

   assign op2_s = immediateMode ?
                  {{(WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate} : op2Reg;
   assign is_mul_s   = aluMode & (aluFunc == 3'b000);
   assign inReady    = (state_r == S_IDLE) | ((state_r == S_DONE) & outReady);
   assign accept_s   = inValid & inReady;
   assign mul_last_s = (state_r == S_MUL) & (cnt_r == {CNT_W{1'b0}});

   // Subtraction is op1 + ~op2 + 1 so the carry-out reads as "no borrow".
   assign add_s = {1'b0, op1Reg} + {1'b0, op2_s};
   assign sub_s = {1'b0, op1Reg} + {1'b0, ~op2_s} + {{WIDTH{1'b0}}, 1'b1};
   assign lsl_s = {1'b0, op1Reg} << op2_s[SHW-1:0];
   assign lsr_s = {op1Reg, 1'b0} >> op2_s[SHW-1:0];
   assign big_shift_s = |op2_s[WIDTH-1:SHW];

   // Single-cycle result and carry/overflow for every non-MUL operation.
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      if (aluMode) begin
         case (aluFunc)
            3'b001: begin
               alu_res_s = add_s[WIDTH-1:0];
               alu_c_s   = add_s[WIDTH];
               alu_v_s   = (op1Reg[WIDTH-1] == op2_s[WIDTH-1]) &
                           (add_s[WIDTH-1] != op1Reg[WIDTH-1]);
            end
            3'b010, 3'b111: begin
               alu_res_s = (aluFunc == 3'b111) ? op1Reg : sub_s[WIDTH-1:0];
               alu_c_s   = sub_s[WIDTH];
               alu_v_s   = (op1Reg[WIDTH-1] != op2_s[WIDTH-1]) &
                           (sub_s[WIDTH-1] != op1Reg[WIDTH-1]);
            end
            3'b011:  alu_res_s = op1Reg & op2_s;
            3'b100:  alu_res_s = op1Reg | op2_s;
            3'b101:  alu_res_s = op1Reg ^ op2_s;
            3'b110:  alu_res_s = ~op1Reg;
            default: alu_res_s = {WIDTH{1'b0}};
         endcase
      end else begin
         case (aluFunc)
            3'b000:  alu_res_s = {{(WIDTH-IMM_WIDTH){1'b0}}, immediate};
            3'b001:  alu_res_s = {immediate, op1Reg[WIDTH-IMM_WIDTH-1:0]};
            3'b010:  alu_res_s = {WIDTH{1'b0}};
            3'b011:  alu_res_s = {WIDTH{1'b1}};
            3'b100, 3'b110: begin
               if (big_shift_s) begin
                  alu_res_s = {WIDTH{1'b0}};
                  alu_c_s   = 1'b0;
               end else begin
                  alu_res_s = lsl_s[WIDTH-1:0];
                  alu_c_s   = lsl_s[WIDTH];
               end
            end
            3'b101, 3'b111: begin
               if (big_shift_s) begin
                  alu_res_s = {WIDTH{1'b0}};
                  alu_c_s   = 1'b0;
               end else begin
                  alu_res_s = lsr_s[WIDTH:1];
                  alu_c_s   = lsr_s[0];
               end
            end
            default: alu_res_s = {WIDTH{1'b0}};
         endcase
      end
   end

   // CMP reports N/Z of the subtraction while returning op1 unchanged.
   assign alu_flags_s = nzcv((aluMode & (aluFunc == 3'b111)) ? sub_s[WIDTH-1:0] : alu_res_s,
                             alu_c_s, alu_v_s);
   assign mul_flags_s = nzcv(acc_r[WIDTH-1:0], |acc_r[2*WIDTH-1:WIDTH], 1'b0);

   // Next-state logic; DONE can retire and accept on the same edge.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (inValid) begin
               state_nxt_s = is_mul_s ? S_MUL : S_DONE;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_MUL: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_MUL;
            end
         end
         S_DONE: begin
            if (outReady) begin
               if (inValid) begin
                  state_nxt_s = is_mul_s ? S_MUL : S_DONE;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Shift-add multiplier: one multiplier bit per cycle, LSB first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r    <= {(2*WIDTH){1'b0}};
         mcand_r  <= {(2*WIDTH){1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else if (accept_s & is_mul_s) begin
         acc_r    <= {(2*WIDTH){1'b0}};
         mcand_r  <= {{WIDTH{1'b0}}, op1Reg};
         mplier_r <= op2_s;
         cnt_r    <= CNT_W'(WIDTH);
      end else if ((state_r == S_MUL) & (cnt_r != {CNT_W{1'b0}})) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end
         mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
         cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Result/flags load only on entry into DONE and hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         results_r <= {WIDTH{1'b0}};
         flags_r   <= 4'b0000;
      end else if (accept_s & ~is_mul_s) begin
         results_r <= alu_res_s;
         flags_r   <= alu_flags_s;
      end else if (mul_last_s) begin
         results_r <= acc_r[WIDTH-1:0];
         flags_r   <= mul_flags_s;
      end
   end

   // Status outputs; busy covers the WIDTH iteration cycles of a MUL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         out_valid_r <= (state_nxt_s == S_DONE);
         busy_r      <= (state_r == S_MUL) & (state_nxt_s == S_MUL);
      end
   end

   assign outValid = out_valid_r;
   assign results  = results_r;
   assign flags    = flags_r;
   assign busy     = busy_r;

endmodule
